wb_port_arbiter: RTL

Sequential arbiter for the single register-file write port at the writeback stage. Shares that port between the in-order pipeline (ALU result or load data) and the multi-cycle mul/div unit. Uses a one-entry hold buffer and a bounded-starvation drain stall. Drives the registered write port and the writeback select lines.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_md_buffer.sv | 59 +++++
 rtl/wb_port_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback write-port arbiter: FSM states,
// writeback source-select encodings and the hard-wired zero register.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        DRAIN = 2'd2
    } wb_state_e;

    // {wb_sel_2, wb_sel_1}; 2'b11 is never produced
    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_MD  = 2'b10;

    localparam int ZERO_REG = 0;

    // Source code for an in-order pipeline write
    function automatic logic [1:0] pipe_src(input logic mem_to_reg);
        return mem_to_reg ? SRC_MEM : SRC_ALU;
    endfunction

endpackage

// File: rtl/wb_md_buffer.sv
// One-entry holding register for a deferred mul/div result. Tracks how many
// consecutive cycles the entry has lost the write port to the pipeline.
module wb_md_buffer
    import wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o
);

    localparam int AGE_W = $clog2(STARVE_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_SAT = '1;

    logic              valid_q;
    logic [AGE_W-1:0]  age_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    // Occupancy flag and saturating starvation age; load restarts the age
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            age_q   <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            age_q   <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
            age_q   <= '0;
        end else if (inc_i && (age_q != AGE_SAT)) begin
            age_q   <= age_q + 1'b1;
        end
    end

    // Payload only needs capturing; its content is meaningless while empty
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            addr_q <= addr_i;
            data_q <= data_i;
        end
    end

    assign addr_o = addr_q;
    assign data_o = data_q;
    // One more lost cycle would reach the starvation limit
    assign last_o = valid_q && ((int'(age_q) + 1) == STARVE_MAX);

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback write-port arbiter: shares the register-file write port between
// the in-order pipeline and the mul/div unit, parking a colliding mul/div
// result in a one-entry buffer and forcing a one-cycle drain stall if the
// pipeline keeps winning for STARVE_MAX cycles.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              pipe_wr_en,
    input  logic              pipe_mem_to_reg,
    input  logic [ADDR_W-1:0] pipe_wr_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              md_valid,
    input  logic [ADDR_W-1:0] md_wr_addr,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              wb_sel_1,
    output logic              wb_sel_2,
    output logic              pipe_stall,
    output logic              md_pending
);

    wb_state_e         state_q, state_d;

    logic              buf_load, buf_clr, buf_inc, buf_last;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;

    logic              wr_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0] wdata_d;
    logic [1:0]        wsel_d;

    logic              rf_wr_en_q;
    logic [ADDR_W-1:0] rf_wr_addr_q;
    logic [DATA_W-1:0] rf_wr_data_q;
    logic [1:0]        wsel_q;

    logic [DATA_W-1:0] pipe_data;

    assign pipe_data = pipe_mem_to_reg ? mem_data : alu_data;

    wb_md_buffer #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (STARVE_MAX)
    ) u_md_buffer (
        .clk_i  (Clk),
        .rst_ni (Reset_n),
        .load_i (buf_load),
        .clr_i  (buf_clr),
        .inc_i  (buf_inc),
        .addr_i (md_wr_addr),
        .data_i (md_data),
        .addr_o (buf_addr),
        .data_o (buf_data),
        .last_o (buf_last)
    );

    // FSM state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, buffer control and the write the port performs this cycle
    always_comb begin
        state_d  = state_q;
        wr_d     = 1'b0;
        waddr_d  = '0;
        wdata_d  = '0;
        wsel_d   = SRC_ALU;
        buf_load = 1'b0;
        buf_clr  = 1'b0;
        buf_inc  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pipe_wr_en) begin
                    wr_d    = 1'b1;
                    waddr_d = pipe_wr_addr;
                    wdata_d = pipe_data;
                    wsel_d  = pipe_src(pipe_mem_to_reg);
                    // Same destination: the pipeline result is younger, so md is dropped
                    if (md_valid && (md_wr_addr != pipe_wr_addr)) begin
                        buf_load = 1'b1;
                        state_d  = HELD;
                    end
                end else if (md_valid) begin
                    wr_d    = 1'b1;
                    waddr_d = md_wr_addr;
                    wdata_d = md_data;
                    wsel_d  = SRC_MD;
                end
            end
            HELD: begin
                if (!pipe_wr_en) begin
                    wr_d    = 1'b1;
                    waddr_d = buf_addr;
                    wdata_d = buf_data;
                    wsel_d  = SRC_MD;
                    buf_clr = 1'b1;
                    state_d = IDLE;
                end else begin
                    wr_d    = 1'b1;
                    waddr_d = pipe_wr_addr;
                    wdata_d = pipe_data;
                    wsel_d  = pipe_src(pipe_mem_to_reg);
                    if (pipe_wr_addr == buf_addr) begin
                        // Held result is overwritten by a younger one; never write it
                        buf_clr = 1'b1;
                        state_d = IDLE;
                    end else begin
                        buf_inc = 1'b1;
                        if (buf_last) begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                wr_d    = 1'b1;
                waddr_d = buf_addr;
                wdata_d = buf_data;
                wsel_d  = SRC_MD;
                buf_clr = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore handshake and status outputs
    always_comb begin
        md_ready   = (state_q == IDLE);
        md_pending = (state_q != IDLE);
        pipe_stall = (state_q == DRAIN);
    end

    // Registered write port; writes to the zero register are squashed
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_data_q <= '0;
            wsel_q       <= SRC_ALU;
        end else begin
            rf_wr_en_q <= wr_d && (waddr_d != ADDR_W'(ZERO_REG));
            if (wr_d) begin
                rf_wr_addr_q <= waddr_d;
                rf_wr_data_q <= wdata_d;
                wsel_q       <= wsel_d;
            end
        end
    end

    assign rf_wr_en   = rf_wr_en_q;
    assign rf_wr_addr = rf_wr_addr_q;
    assign rf_wr_data = rf_wr_data_q;
    assign wb_sel_1   = wsel_q[0];
    assign wb_sel_2   = wsel_q[1];

endmodule
